// File: rtl/gpio_pkg.sv
// gpio_pkg: register map shared by gpio_port and its bench
package gpio_pkg;
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_DIR    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_MASK   = 2'd3;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: multi-flop synchroniser bringing asynchronous pad levels into clk
// Ports: clk, reset (sync, active-high), i_d raw pads in, o_q last synchroniser stage out.
module gpio_sync #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_stage [SYNC_STAGES];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_stage[s] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int s = 1; s < SYNC_STAGES; s++) r_stage[s] <= r_stage[s-1];
        end
    end
    assign o_q = r_stage[SYNC_STAGES-1];
endmodule

// File: rtl/gpio_port.sv
// gpio_port: bidirectional GPIO port with per-pin direction and optional rising-edge interrupts
// Ports: clk, reset (sync, active-high), PIN pads, addr register select (DATA/DIR/STATUS/MASK),
//        load write strobe, dataW write data, dataR combinational read data, irq level interrupt.
// Edge detection, STATUS/MASK and irq exist only when GPIO_EDGE_IRQ_EN is defined.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] PIN,
    input  logic [1:0]       addr,
    input  logic             load,
    input  logic [WIDTH-1:0] dataW,
    output logic [WIDTH-1:0] dataR,
    output logic             irq
);
    logic [WIDTH-1:0] r_out, r_dir, w_pin_sync;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
            r_dir <= '0;
        end else begin
            if (load && addr == ADDR_DATA) r_out <= dataW;
            if (load && addr == ADDR_DIR)  r_dir <= dataW;
        end
    end
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_pad
        assign PIN[i] = r_dir[i] ? r_out[i] : 1'bz;
    end
    gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (PIN),
        .o_q   (w_pin_sync)
    );
`ifdef GPIO_EDGE_IRQ_EN
    // Arming waits until the synchroniser has flushed post-reset pad levels,
    // so pins already high at reset release do not look like rising edges.
    localparam int ARM_CNT = SYNC_STAGES + 1;
    localparam int CW      = $clog2(ARM_CNT + 1);
    logic [WIDTH-1:0] r_status, r_mask, r_prev, w_rise, w_clr;
    logic [CW-1:0]    r_arm_cnt;
    logic             w_armed;
    assign w_armed = r_arm_cnt == CW'(ARM_CNT);
    assign w_rise  = w_pin_sync & ~r_prev & ~r_dir;
    assign w_clr   = (load && addr == ADDR_STATUS) ? dataW : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status  <= '0;
            r_mask    <= '0;
            r_prev    <= '0;
            r_arm_cnt <= '0;
        end else begin
            r_prev <= w_pin_sync;
            if (!w_armed) r_arm_cnt <= r_arm_cnt + CW'(1);
            if (load && addr == ADDR_MASK) r_mask <= dataW;
            // set is OR'ed after the clear so a coincident rise wins
            r_status <= (r_status & ~w_clr) | (w_armed ? w_rise : '0);
        end
    end
    assign irq = |(r_status & r_mask);
    always_comb dataR = addr == ADDR_DATA   ? w_pin_sync :
                        addr == ADDR_DIR    ? r_dir      :
                        addr == ADDR_STATUS ? r_status   : r_mask;
`else
    assign irq = 1'b0;
    always_comb dataR = addr == ADDR_DATA ? w_pin_sync :
                        addr == ADDR_DIR  ? r_dir      : '0;
`endif
endmodule
